// File: rtl/grn_pkg.sv
// Shared GRN types and defaults: result line type and write-buffer depth.
package grn_pkg;

    localparam int unsigned GRN_LINE_W      = 512;
    localparam int unsigned GRN_WRBUF_DEPTH = 16;

    typedef logic [GRN_LINE_W-1:0] t_grn_line;

endpackage

// File: rtl/grn_wrbuf_mem.sv
// Write-buffer storage: DEPTH x DATA_WIDTH flops, one sync write port, one async read port.
module grn_wrbuf_mem #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/grn_write_buffer.sv
// Elastic result-line buffer between the GRN core and the requestor; holds finish until drained.
// Optional GRN_WRBUF_STATS_EN adds lines_total / occ_max statistics outputs.
module grn_write_buffer
    import grn_pkg::*;
#(
    parameter int unsigned DEPTH      = GRN_WRBUF_DEPTH,
    parameter int unsigned DATA_WIDTH = GRN_LINE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  t_grn_line              transient_in,
    input  logic                   req_write_in,
    output logic                   ack_write_out,
    input  logic                   finish_in,
    output t_grn_line              transient_out,
    output logic                   req_write_out,
    input  logic                   ack_write_in,
    output logic                   finish_out,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   proto_err
`ifdef GRN_WRBUF_STATS_EN
    ,
    output logic [31:0]            lines_total,
    output logic [$clog2(DEPTH):0] occ_max
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             req_q, req_d, ack_q, ack_d;
    logic             seen_q, seen_d, fin_q, fin_d, perr_q, perr_d;
    t_grn_line        head_q, head_d, rd_data;
    logic             push, pop;

    grn_wrbuf_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !clear),
        .waddr (wr_ptr_q),
        .wdata (transient_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign push = req_write_in && !ack_q && (occ_q < OCC_W'(DEPTH));
    assign pop  = req_q && ack_write_in;

    // Next-state: pointers, occupancy, downstream valid with one-cycle gap after each pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        req_d    = req_q;
        ack_d    = ack_q;
        head_d   = head_q;
        seen_d   = seen_q;
        fin_d    = fin_q;
        perr_d   = perr_q | (ack_write_in & ~req_q);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            req_d    = 1'b0;
            ack_d    = 1'b0;
            seen_d   = 1'b0;
            fin_d    = 1'b0;
        end else begin
            ack_d = push;
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
            if (pop) begin
                req_d = 1'b0;
            end else if (!req_q && (occ_d != '0)) begin
                // An empty buffer presents the incoming line directly.
                req_d  = 1'b1;
                head_d = (occ_q == '0) ? transient_in : rd_data;
            end
            seen_d = seen_q | finish_in;
            fin_d  = fin_q | (seen_q && (occ_q == '0) && !req_q && !push);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            req_q    <= 1'b0;
            ack_q    <= 1'b0;
            head_q   <= '0;
            seen_q   <= 1'b0;
            fin_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            head_q   <= head_d;
            seen_q   <= seen_d;
            fin_q    <= fin_d;
            perr_q   <= perr_d;
        end
    end

    assign transient_out = head_q;
    assign req_write_out = req_q;
    assign ack_write_out = ack_q;
    assign finish_out    = fin_q;
    assign occupancy     = occ_q;
    assign proto_err     = perr_q;

`ifdef GRN_WRBUF_STATS_EN
    logic [31:0]      lines_q, lines_d;
    logic [OCC_W-1:0] occ_max_q, occ_max_d;

    always_comb begin
        lines_d   = lines_q;
        occ_max_d = occ_max_q;
        if (clear) begin
            lines_d   = '0;
            occ_max_d = '0;
        end else begin
            lines_d = lines_q + 32'(pop);
            if (occ_d > occ_max_q) occ_max_d = occ_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_q   <= '0;
            occ_max_q <= '0;
        end else begin
            lines_q   <= lines_d;
            occ_max_q <= occ_max_d;
        end
    end

    assign lines_total = lines_q;
    assign occ_max     = occ_max_q;
`endif

endmodule

// File: doc/grn_write_buffer.md
# grn_write_buffer

Elastic result-line buffer between `top_grn` and `grn_requestor`. It accepts 512-bit result lines from the GRN core over the `req_write`/`ack_write` handshake, stores up to `DEPTH` lines, and replays them in order to the requestor using the same handshake. This decouples core progress from CCI-P write back-pressure. It also withholds the core's `finish` until every buffered line has been handed off, so the DSM completion write never overtakes result data.

## Interface
- `DEPTH`, 16: buffer entries; power of two, at least 2.
- `DATA_WIDTH`, 512: line width; equals one CCI-P cache line.

- `clk`  in  1  AFU clock (pClkDiv2 domain).
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush, driven by the requestor's `top_grn_reset`.
- `transient_in`  in  DATA_WIDTH  upstream line; stable while `req_write_in` is high.
- `req_write_in`  in  1  upstream line valid.
- `ack_write_out`  out  1  one-cycle accept pulse to upstream.
- `finish_in`  in  1  upstream done; may be a pulse or a level.
- `transient_out`  out  DATA_WIDTH  head-of-buffer line.
- `req_write_out`  out  1  downstream line valid.
- `ack_write_in`  in  1  downstream accept.
- `finish_out`  out  1  done, qualified by the buffer being drained.
- `occupancy`  out  $clog2(DEPTH)+1  current entry count.
- `proto_err`  out  1  sticky flag: `ack_write_in` was seen while `req_write_out` was low.

## Operation
- **Reset values.** On `reset` all outputs are 0: `transient_out`, `req_write_out`, `ack_write_out`, `finish_out`, `occupancy` and `proto_err`. Pointers and the `finish_seen` flag are also 0.
- **Push.** A push happens at an edge where `req_write_in`=1, `ack_write_out`=0 and `occupancy`<DEPTH.
  - The line is written at that edge and `ack_write_out`=1 for the following cycle only.
  - Because of the ack cycle, upstream accepts occur at most every other cycle.
- **Full.** When `occupancy`==DEPTH, no ack is issued and upstream holds `req_write_in` with its data.
- **Pop.** A pop happens at an edge where `req_write_out`=1 and `ack_write_in`=1.
  - After a pop, `req_write_out` is 0 for exactly one cycle (the gap cycle).
  - After the gap, it re-asserts with the next head line if `occupancy`>0.
- **Simultaneous push and pop.** `occupancy` is unchanged and both pointers advance.
- **Wrap-around.** Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty is decided by `occupancy`, not by pointer comparison.
- **Finish.**
  - `finish_in` sets the sticky `finish_seen` flag.
  - `finish_out` is registered: it is 1 when `finish_seen` is set, `occupancy`==0 and `req_write_out`==0.
  - Once set, `finish_out` holds until `clear` or `reset`.
  - A push arriving after `finish_in` delays `finish_out` until that push has also drained.
- **Clear.** `clear` empties the buffer and zeroes pointers, `finish_seen`, `finish_out`, `req_write_out` and `ack_write_out` at the next edge. Pushes and pops in the same cycle as `clear` are discarded. `proto_err` is kept.
- **Protocol error.** `ack_write_in` while `req_write_out`=0 sets `proto_err` and is otherwise ignored; no pop occurs.

## Timing
- **Push to downstream valid.** `req_write_in` sampled at edge E into an empty buffer gives `ack_write_out`=1 and `req_write_out`=1 both in the cycle after E, with `transient_out` valid.
- **Downstream signals.** `req_write_out` and `transient_out` come from registers; there is no combinational path from any input to any output.
- **Upstream rate.** A maximum of one upstream accept per 2 cycles.
- **Downstream rate.** A maximum of one downstream pop per 2 cycles.
- **Freed slot.** A slot freed by a pop at edge E can be filled at edge E+1 at the earliest. Full status is taken from registered `occupancy`; there is no same-edge bypass.
- **Finish after last pop.** `finish_out` rises 1 cycle after the edge where the last pop drops `occupancy` to 0.

## Configuration
- **`GRN_WRBUF_STATS_EN` defined:** adds two outputs, both cleared by `reset` and `clear`:
  - `lines_total` (32 bits): count of pops; wraps at 2^32.
  - `occ_max` (`$clog2(DEPTH)+1` bits): high-water mark of `occupancy`.
- **Undefined:** neither port exists and no counter logic is built. Core behaviour is identical in both cases.

## Structure
- **Additions to `grn_pkg`:**
  - `GRN_WRBUF_DEPTH`, the default depth.
  - `t_grn_line`, a `logic [511:0]` typedef used for `transient_in`/`transient_out`.
- **Sub-module `grn_wrbuf_mem`:** DEPTH×DATA_WIDTH flop array with one synchronous write port and one asynchronous read port. `grn_write_buffer` registers the read data into `transient_out`.

## Test plan
- **Single line:** after reset, push `transient_in`=512'hA5…A5. Expect `ack_write_out` and `req_write_out` 1 cycle later, `transient_out`=A5…A5. Assert `ack_write_in` → `occupancy` 0, `req_write_out` low.
- **Fill with stalled downstream:** push 17 lines with `ack_write_in`=0 and DEPTH=16. Expect 16 acks, `occupancy`=16, 17th `req_write_in` held un-acked. One pop → 17th acked ≥1 cycle later. Order 0..16 preserved; exercises wrap.
- **Concurrent push/pop:** with `occupancy`=5, push and pop on the same edge → `occupancy` stays 5 and data order is intact.
- **Finish ordering:** 3 lines buffered, then `finish_in` pulse → `finish_out` stays 0. It rises exactly 1 cycle after the third pop and holds.
- **Clear mid-stream:** 7 lines buffered with `finish_seen` set, assert `clear` → next cycle `occupancy`=0, `req_write_out`=0, `finish_out`=0. Upstream pushes accepted again afterwards.
- **Protocol error and reset:** `ack_write_in` while empty → `proto_err`=1 and `occupancy` unchanged. Async `reset` asserted mid-cycle → all outputs 0 immediately.
